// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the rotation-mode CORDIC pipeline.
package cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int K_INV   = 'h4DBA;  // 1/K ~= 0.60725 in Q15

    function automatic int calc_iw(input int data_w, input int guard);
        return data_w + guard + 2;
    endfunction

    // atan(2^-i) in angle units (2^16 = 2*pi), held with 4 fractional bits and
    // re-scaled to the requested guard width with round-to-nearest.
    function automatic int atan_tab(input int i, input int guard);
        int t16;
        case (i)
            0:       t16 = 131072;
            1:       t16 = 77376;
            2:       t16 = 40884;
            3:       t16 = 20753;
            4:       t16 = 10417;
            5:       t16 = 5213;
            6:       t16 = 2607;
            7:       t16 = 1304;
            8:       t16 = 652;
            9:       t16 = 326;
            10:      t16 = 163;
            11:      t16 = 81;
            12:      t16 = 41;
            13:      t16 = 20;
            14:      t16 = 10;
            15:      t16 = 5;
            default: t16 = 0;
        endcase
        if (guard >= 4)
            return t16 <<< (guard - 4);
        else
            return (t16 + (1 << (3 - guard))) >>> (4 - guard);
    endfunction

endpackage

// File: rtl/cordic_rot_stage.sv
// One registered CORDIC micro-rotation: rotates (x, y) by +/-atan(2^-SHIFT)
// toward driving the residual angle z to zero.
module cordic_rot_stage #(
    parameter int IW    = 22,
    parameter int ZW    = 20,
    parameter int SHIFT = 0,
    parameter int ATAN  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_i,
    input  logic [IW-1:0] x_i,
    input  logic [IW-1:0] y_i,
    input  logic [ZW-1:0] z_i,
    output logic          vld_q,
    output logic [IW-1:0] x_q,
    output logic [IW-1:0] y_q,
    output logic [ZW-1:0] z_q
);

    localparam logic [ZW-1:0] ATAN_Z = ZW'(ATAN);

    logic          vld_d;
    logic [IW-1:0] x_d, y_d, xs, ys;
    logic [ZW-1:0] z_d;

    always_comb begin
        vld_d = vld_i;
        xs    = $signed(x_i) >>> SHIFT;
        ys    = $signed(y_i) >>> SHIFT;
        if (!z_i[ZW-1]) begin
            x_d = x_i - ys;
            y_d = y_i + xs;
            z_d = z_i - ATAN_Z;
        end else begin
            x_d = x_i + ys;
            y_d = y_i - xs;
            z_d = z_i + ATAN_Z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            vld_q <= vld_d;
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

endmodule

// File: rtl/rotate_cordic.sv
// Rotation-mode CORDIC: (magnitude, phase) -> (r*cos, r*sin), fully pipelined,
// latency ITER+2, one sample per clock.
module rotate_cordic
    import cordic_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ITER   = 16,
    parameter int GUARD  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] mag_in,
    input  logic [15:0]       angle_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out
);

    localparam int IW = calc_iw(DATA_W, GUARD);
    localparam int ZW = ANGLE_W + GUARD;
    localparam int PW = IW + 16;

    localparam logic [DATA_W-1:0]    MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [PW-1:0]        KMUL    = PW'(K_INV);
    localparam logic signed [IW-1:0] RND     = IW'(1 << (GUARD - 1));
    localparam logic signed [IW-1:0] SAT_HI  = IW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_LO  = -SAT_HI;

    // Stage A: saturate and align to the guard-extended internal grid
    logic              a_vld_d, a_vld_q;
    logic [IW-1:0]     a_mag_d, a_mag_q;
    logic [ZW-1:0]     a_ang_d, a_ang_q;
    logic [DATA_W-1:0] mag_sat;

    always_comb begin
        mag_sat = (mag_in > MAG_MAX) ? MAG_MAX : mag_in;
        a_vld_d = valid_in;
        a_mag_d = IW'(mag_sat) << GUARD;
        a_ang_d = ZW'(angle_in) << GUARD;
    end

    // Stage B: pre-scale by 1/K and fold the outer half-plane onto |z| <= 90 deg
    logic          b_vld_d, b_vld_q;
    logic [IW-1:0] b_x_d, b_x_q, b_y_d, b_y_q, x0;
    logic [ZW-1:0] b_z_d, b_z_q;
    logic [PW-1:0] prod;
    logic          fold;

    always_comb begin
        prod    = PW'(a_mag_q) * KMUL;
        x0      = IW'(prod >> 15);
        fold    = a_ang_q[ZW-1] ^ a_ang_q[ZW-2];
        b_vld_d = a_vld_q;
        b_y_d   = '0;
        if (fold) begin
            b_x_d = -x0;
            b_z_d = a_ang_q ^ {1'b1, {(ZW-1){1'b0}}};
        end else begin
            b_x_d = x0;
            b_z_d = a_ang_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q <= 1'b0;
            a_mag_q <= '0;
            a_ang_q <= '0;
            b_vld_q <= 1'b0;
            b_x_q   <= '0;
            b_y_q   <= '0;
            b_z_q   <= '0;
        end else begin
            a_vld_q <= a_vld_d;
            a_mag_q <= a_mag_d;
            a_ang_q <= a_ang_d;
            b_vld_q <= b_vld_d;
            b_x_q   <= b_x_d;
            b_y_q   <= b_y_d;
            b_z_q   <= b_z_d;
        end
    end

    logic          st_v [0:ITER];
    logic [IW-1:0] st_x [0:ITER];
    logic [IW-1:0] st_y [0:ITER];
    logic [ZW-1:0] st_z [0:ITER];

    assign st_v[0] = b_vld_q;
    assign st_x[0] = b_x_q;
    assign st_y[0] = b_y_q;
    assign st_z[0] = b_z_q;

    for (genvar g = 0; g < ITER; g++) begin : g_stage
        cordic_rot_stage #(
            .IW    (IW),
            .ZW    (ZW),
            .SHIFT (g),
            .ATAN  (atan_tab(g, GUARD))
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .vld_i (st_v[g]),
            .x_i   (st_x[g]),
            .y_i   (st_y[g]),
            .z_i   (st_z[g]),
            .vld_q (st_v[g+1]),
            .x_q   (st_x[g+1]),
            .y_q   (st_y[g+1]),
            .z_q   (st_z[g+1])
        );
    end

    // The final residual angle has no consumer.
    logic unused_z;
    assign unused_z = ^st_z[ITER];

    function automatic logic [DATA_W-1:0] rnd_sat(input logic [IW-1:0] v);
        logic signed [IW-1:0] r;
        logic [DATA_W-1:0]    res;
        r = ($signed(v) + RND) >>> GUARD;
        if (r > SAT_HI)
            res = DATA_W'(SAT_HI);
        else if (r < SAT_LO)
            res = DATA_W'(SAT_LO);
        else
            res = DATA_W'(r);
        return res;
    endfunction

    logic              o_vld_d, o_vld_q;
    logic [DATA_W-1:0] o_x_d, o_x_q, o_y_d, o_y_q;

    always_comb begin
        o_vld_d = st_v[ITER];
        o_x_d   = rnd_sat(st_x[ITER]);
        o_y_d   = rnd_sat(st_y[ITER]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld_q <= 1'b0;
            o_x_q   <= '0;
            o_y_q   <= '0;
        end else begin
            o_vld_q <= o_vld_d;
            o_x_q   <= o_x_d;
            o_y_q   <= o_y_d;
        end
    end

    assign valid_out = o_vld_q;
    assign x_out     = o_x_q;
    assign y_out     = o_y_q;

endmodule

// File: tb/tb_rotate_cordic.sv
// Directed-vector, random-stream and mid-stream-reset checks for rotate_cordic.
module tb_rotate_cordic;

    localparam int  DATA_W = 16;
    localparam int  ITER   = 16;
    localparam int  GUARD  = 4;
    localparam int  LAT    = ITER + 2;
    localparam int  NRND   = 1000;
    localparam int  NH     = NRND + LAT + 2;
    localparam real PI     = 3.14159265358979;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              valid_in = 1'b0;
    logic [DATA_W-1:0] mag_in   = '0;
    logic [15:0]       angle_in = '0;
    logic              valid_out;
    logic [DATA_W-1:0] x_out, y_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rotate_cordic #(
        .DATA_W (DATA_W),
        .ITER   (ITER),
        .GUARD  (GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .mag_in    (mag_in),
        .angle_in  (angle_in),
        .valid_out (valid_out),
        .x_out     (x_out),
        .y_out     (y_out)
    );

    typedef struct {
        logic [15:0] mag;
        logic [15:0] ang;
        int          ex;
        int          ey;
    } vec_t;

    vec_t tab [11];

    task automatic chk(input string nm, input int got, input int exp, input int tol);
        total++;
        if (got > exp + tol || got < exp - tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, got, exp, tol);
        end
    endtask

    // One isolated sample; checks latency and the first result that appears.
    task automatic apply_vec(input string nm, input logic [15:0] m, input logic [15:0] a,
                             input int ex, input int ey);
        int seen;
        int gx;
        int gy;
        seen = -1;
        gx   = 999999;
        gy   = 999999;
        @(posedge clk); #1;
        valid_in = 1'b1; mag_in = m; angle_in = a;
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_out && seen < 0) begin
                seen = c;
                gx   = int'($signed(x_out));
                gy   = int'($signed(y_out));
            end
        end
        chk({nm, " latency"}, seen, LAT, 0);
        chk({nm, " x"}, gx, ex, 3);
        chk({nm, " y"}, gy, ey, 3);
    endtask

    logic vin_h [NH];
    int   m_h   [NH];
    int   a_h   [NH];

    initial begin
        int  j, ms, ex, ey, gx, gy, vcnt;
        real th, mr;

        tab[0]  = '{16'd10000, 16'h0000,  10000,      0};
        tab[1]  = '{16'd10000, 16'h4000,      0,  10000};
        tab[2]  = '{16'd10000, 16'h8000, -10000,      0};
        tab[3]  = '{16'd10000, 16'hC000,      0, -10000};
        tab[4]  = '{16'd10000, 16'h2000,   7071,   7071};
        tab[5]  = '{16'd10000, 16'hA000,  -7071,  -7071};
        tab[6]  = '{16'hFFFF,  16'h0000,  32767,      0};
        tab[7]  = '{16'd0,     16'h1234,      0,      0};
        tab[8]  = '{16'd20000, 16'h6000, -14142,  14142};
        tab[9]  = '{16'd32767, 16'hE000,  23170, -23170};
        tab[10] = '{16'd1000,  16'h1555,    866,    500};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset valid_out", int'(valid_out), 0, 0);
        chk("reset x_out", int'(x_out), 0, 0);
        chk("reset y_out", int'(y_out), 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            apply_vec($sformatf("vec%0d", i), tab[i].mag, tab[i].ang, tab[i].ex, tab[i].ey);

        // Random stream with gaps; output order and gap pattern must follow input
        for (int k = 0; k < NH; k++) begin
            @(posedge clk); #1;
            if (k < NRND) begin
                valid_in = ($urandom_range(0, 3) != 0);
                mag_in   = 16'($urandom);
                angle_in = 16'($urandom);
            end else begin
                valid_in = 1'b0;
            end
            vin_h[k] = valid_in;
            m_h[k]   = int'(mag_in);
            a_h[k]   = int'(angle_in);
            @(negedge clk);
            j = k - 1 - LAT;
            chk("rnd valid", int'(valid_out), (j >= 0) ? int'(vin_h[j]) : 0, 0);
            if (j >= 0 && vin_h[j]) begin
                ms = (m_h[j] > 32767) ? 32767 : m_h[j];
                th = real'(a_h[j]) * 2.0 * PI / 65536.0;
                ex = int'(real'(ms) * $cos(th));
                ey = int'(real'(ms) * $sin(th));
                gx = int'($signed(x_out));
                gy = int'($signed(y_out));
                chk("rnd x", gx, ex, 3);
                chk("rnd y", gy, ey, 3);
                mr = $sqrt(real'(gx) * real'(gx) + real'(gy) * real'(gy));
                chk("rnd magnitude", int'(mr), ms, 4);
            end
        end

        // Mid-stream reset: 5 samples in flight plus one coincident with rst
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1; mag_in = 16'd5000 + 16'(i); angle_in = 16'h1000;
        end
        @(posedge clk); #1;
        rst = 1'b1; valid_in = 1'b1; mag_in = 16'd12345; angle_in = 16'h3000;
        @(posedge clk); #1;
        rst = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        chk("post-reset valid_out", int'(valid_out), 0, 0);
        chk("post-reset x_out", int'(x_out), 0, 0);
        chk("post-reset y_out", int'(y_out), 0, 0);
        vcnt = 0;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_out) vcnt++;
        end
        chk("flushed valid count", vcnt, 0, 0);

        apply_vec("first after reset", 16'd10000, 16'h2000, 7071, 7071);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
